// File: rtl/trail_writer_mp_if.sv
// Bundled tick/ROM/frame-buffer signals of trail_writer_mp.
// The slave modport is the engine side; the master modport is the game/memory side.
interface trail_writer_mp_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 6,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16,
  parameter int ROM_AW      = 6
);
  logic                          frame_clk;
  logic                          active;
  logic                          clear;
  logic [NUM_PLAYERS*GRID_W-1:0] pos_x;
  logic [NUM_PLAYERS*GRID_W-1:0] pos_y;
  logic [NUM_PLAYERS*2-1:0]      dir;
  logic [ROM_AW-1:0]             rom_addr;
  logic [DATA_W-1:0]             rom_data;
  logic [ADDR_W-1:0]             fb_addr;
  logic [DATA_W-1:0]             fb_data;
  logic                          fb_we;
  logic                          fb_ready;
  logic [NUM_PLAYERS-1:0]        collision;
  logic                          busy;
  logic                          overrun;

  modport slave (
    input  frame_clk, active, clear, pos_x, pos_y, dir, rom_data, fb_ready,
    output rom_addr, fb_addr, fb_data, fb_we, collision, busy, overrun
  );

  modport master (
    output frame_clk, active, clear, pos_x, pos_y, dir, rom_data, fb_ready,
    input  rom_addr, fb_addr, fb_data, fb_we, collision, busy, overrun
  );
endinterface

// File: rtl/trail_writer_mp.sv
// Multi-player light-cycle trail engine: occupancy grid, collision flags and tile blit.
// Build macro TRAIL_SELF_HIT_EN: when defined, a player's own trail also counts as a hit.
module trail_writer_mp #(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 6,
  parameter int TILE_H      = 4,
  parameter int TILE_WPR    = 2,
  parameter int ROW_PITCH   = 320,
  parameter int FB_BASE     = 0,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  trail_writer_mp_if.slave bus
);
  localparam int PI_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int WORDS  = TILE_H * TILE_WPR;
  localparam int WD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int R_W    = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int C_W    = (TILE_WPR > 1) ? $clog2(TILE_WPR) : 1;
  localparam int IDX_W  = 2 * GRID_W;
  localparam int CODE_W = $clog2(NUM_PLAYERS + 1);
  localparam int ROM_AW = PI_W + 2 + WD_W;

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_CHK, S_MARK, S_FETCH, S_WR, S_CLEAR} state_t;
  state_t state_q, state_d;

  logic [GRID_W-1:0] old_x_q [NUM_PLAYERS];
  logic [GRID_W-1:0] old_y_q [NUM_PLAYERS];
  logic [1:0]        old_d_q [NUM_PLAYERS];
  logic [GRID_W-1:0] jo_x_q  [NUM_PLAYERS];
  logic [GRID_W-1:0] jo_y_q  [NUM_PLAYERS];
  logic [GRID_W-1:0] jn_x_q  [NUM_PLAYERS];
  logic [GRID_W-1:0] jn_y_q  [NUM_PLAYERS];
  logic [1:0]        jk_q    [NUM_PLAYERS];
  logic [GRID_W-1:0] cur_x   [NUM_PLAYERS];
  logic [GRID_W-1:0] cur_y   [NUM_PLAYERS];
  logic [1:0]        cur_d   [NUM_PLAYERS];
  logic [1:0]        kind_n  [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] moved, pend_q, coll_q;

  logic [CODE_W-1:0] grid_q [2**IDX_W];
  logic [CODE_W-1:0] rd_q, own_code, grid_wdata;
  logic [IDX_W-1:0]  rd_idx, grid_widx, clr_idx_q;
  logic              grid_we, hit, tick, pick_vld, accept, last_word;
  logic              ovr_q, clr_req_q, dv_q;
  logic [PI_W-1:0]   pick, sel_q;
  logic [1:0]        kind_q;
  logic [GRID_W-1:0] cx_q, cy_q;
  logic [R_W-1:0]    r_q;
  logic [C_W-1:0]    c_q;
  logic [WD_W-1:0]   word_c;
  logic [ADDR_W-1:0] fb_addr_c;
  logic [DATA_W-1:0] fb_data_c;
  logic [ROM_AW-1:0] rom_addr_c;

  // A clear pulse on the same cycle as frame_clk swallows the tick.
  assign tick = bus.frame_clk && bus.active && !bus.clear;

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cur_x[p] = bus.pos_x[p*GRID_W +: GRID_W];
      cur_y[p] = bus.pos_y[p*GRID_W +: GRID_W];
      cur_d[p] = bus.dir[p*2 +: 2];
      moved[p] = (cur_x[p] != old_x_q[p]) || (cur_y[p] != old_y_q[p]);
      if (cur_d[p] != old_d_q[p]) kind_n[p] = 2'd2;
      else if (cur_d[p][1])       kind_n[p] = 2'd0;
      else                        kind_n[p] = 2'd1;
    end
  end

  always_comb begin
    pick_vld = |pend_q;
    pick     = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--)
      if (pend_q[p]) pick = PI_W'(p);
  end

  assign rd_idx     = {jn_y_q[pick], jn_x_q[pick]};
  assign own_code   = CODE_W'(sel_q) + CODE_W'(1);
  assign grid_we    = (state_q == S_MARK) || (state_q == S_CLEAR);
  assign grid_widx  = (state_q == S_CLEAR) ? clr_idx_q : {cy_q, cx_q};
  assign grid_wdata = (state_q == S_CLEAR) ? '0 : own_code;

`ifdef TRAIL_SELF_HIT_EN
  assign hit = (rd_q != '0);
`else
  assign hit = (rd_q != '0) && (rd_q != own_code);
`endif

  assign accept    = (state_q == S_WR) && dv_q && bus.fb_ready && bus.active;
  assign last_word = (r_q == R_W'(TILE_H - 1)) && (c_q == C_W'(TILE_WPR - 1));
  assign word_c    = WD_W'(r_q) * WD_W'(TILE_WPR) + WD_W'(c_q);
  assign rom_addr_c = {sel_q, kind_q, word_c};
  assign fb_addr_c = ADDR_W'(FB_BASE)
                   + (ADDR_W'(cy_q) * ADDR_W'(TILE_H) + ADDR_W'(r_q)) * ADDR_W'(ROW_PITCH)
                   + ADDR_W'(cx_q) * ADDR_W'(TILE_WPR) + ADDR_W'(c_q);
  assign fb_data_c = bus.rom_data;

  assign bus.rom_addr  = rom_addr_c;
  assign bus.fb_we     = (state_q == S_WR) && dv_q && bus.active;
  assign bus.fb_addr   = (state_q == S_WR) ? fb_addr_c : '0;
  assign bus.fb_data   = (state_q == S_WR) ? fb_data_c : '0;
  assign bus.collision = coll_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.overrun   = ovr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req_q) state_d = S_CLEAR;
               else if (|pend_q) state_d = S_SEL;
      S_SEL:   state_d = (clr_req_q || !pick_vld) ? S_IDLE : S_CHK;
      S_CHK:   state_d = S_MARK;
      S_MARK:  state_d = S_FETCH;
      S_FETCH: state_d = S_WR;
      S_WR:    if (accept && last_word) state_d = S_SEL;
      S_CLEAR: if (clr_idx_q == '1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!bus.active && state_d != S_CLEAR) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      coll_q    <= '0;
      ovr_q     <= 1'b0;
      clr_req_q <= 1'b0;
      sel_q     <= '0;
      kind_q    <= '0;
      r_q       <= '0;
      c_q       <= '0;
      dv_q      <= 1'b0;
      clr_idx_q <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        old_x_q[p] <= '0;
        old_y_q[p] <= '0;
        old_d_q[p] <= '0;
      end
    end else begin
      if (bus.clear) clr_req_q <= 1'b1;
      else if (state_q == S_IDLE && state_d == S_CLEAR) clr_req_q <= 1'b0;
      if (state_q == S_SEL && state_d == S_CHK) begin
        pend_q[pick] <= 1'b0;
        sel_q        <= pick;
        kind_q       <= jk_q[pick];
        r_q          <= '0;
        c_q          <= '0;
        dv_q         <= 1'b0;
      end
      if (state_q == S_CHK && hit) coll_q[sel_q] <= 1'b1;
      if (state_q == S_FETCH) dv_q <= 1'b1;
      // Each accepted word re-addresses the ROM, so one bubble follows it.
      if (state_q == S_WR) begin
        if (accept) begin
          dv_q <= 1'b0;
          if (c_q == C_W'(TILE_WPR - 1)) begin
            c_q <= '0;
            r_q <= r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end else begin
          dv_q <= 1'b1;
        end
      end
      if (state_q == S_CLEAR) clr_idx_q <= clr_idx_q + 1'b1;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!bus.active || tick) begin
          old_x_q[p] <= cur_x[p];
          old_y_q[p] <= cur_y[p];
          old_d_q[p] <= cur_d[p];
        end
        if (tick && moved[p]) pend_q[p] <= 1'b1;
      end
      if (tick && state_q != S_IDLE) ovr_q <= 1'b1;
      if (!bus.active) begin
        pend_q <= '0;
        dv_q   <= 1'b0;
      end
      if (state_q == S_CLEAR) begin
        pend_q <= '0;
        coll_q <= '0;
        ovr_q  <= 1'b0;
      end
    end
  end

  // Job snapshots, working cell and grid storage carry no reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (tick && moved[p]) begin
        jo_x_q[p] <= old_x_q[p];
        jo_y_q[p] <= old_y_q[p];
        jn_x_q[p] <= cur_x[p];
        jn_y_q[p] <= cur_y[p];
        jk_q[p]   <= kind_n[p];
      end
    end
    if (state_q == S_SEL) begin
      cx_q <= jo_x_q[pick];
      cy_q <= jo_y_q[pick];
    end
    if (grid_we) grid_q[grid_widx] <= grid_wdata;
    rd_q <= grid_q[rd_idx];
  end
endmodule

// File: tb/tb_trail_writer_mp.sv
// Directed bench for trail_writer_mp: move table plus hand sequences for
// ready toggling, overrun, active drop, clear-vs-tick and reset mid-write.
module tb_trail_writer_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trail_writer_mp_if #(.NUM_PLAYERS(2), .GRID_W(6), .ADDR_W(19), .DATA_W(16), .ROM_AW(6)) bus ();
  trail_writer_mp dut (.clk_i(clk), .rst_i(rst), .bus(bus));

`ifdef TRAIL_SELF_HIT_EN
  localparam logic [1:0] CS = 2'b11;
`else
  localparam logic [1:0] CS = 2'b01;
`endif

  typedef struct { logic [18:0] a; logic [15:0] d; } wr_t;
  typedef struct { int p; int nx; int ny; logic [1:0] nd; int a0; int rom0; logic [1:0] coll; } row_t;

  wr_t  wq[$];
  row_t rows[7];
  int   total = 0;
  int   passed = 0;
  int   px[2], py[2];
  logic [1:0] pd[2];
  int   n;

  // Tile ROM: registered, word content tagged with its own address.
  always @(posedge clk) bus.rom_data <= 16'hA000 | {10'd0, bus.rom_addr};

  always @(negedge clk) begin
    wr_t w;
    if (bus.fb_we && bus.fb_ready) begin
      w.a = bus.fb_addr;
      w.d = bus.fb_data;
      wq.push_back(w);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pos();
    for (int p = 0; p < 2; p++) begin
      bus.pos_x[p*6 +: 6] = 6'(px[p]);
      bus.pos_y[p*6 +: 6] = 6'(py[p]);
      bus.dir[p*2 +: 2]   = pd[p];
    end
  endtask

  task automatic pulse_tick(input bit with_clear);
    bus.frame_clk = 1'b1;
    bus.clear     = with_clear;
    step();
    bus.frame_clk = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic run_idle(input string nm, input int budget, input bit toggle, output int cnt);
    cnt = 0;
    step();
    while (bus.busy && cnt < budget) begin
      if (toggle) bus.fb_ready = ~bus.fb_ready;
      step();
      cnt++;
    end
    bus.fb_ready = 1'b1;
    check({nm, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_tile(input string nm, input int base, input int a0, input int rom0);
    for (int w = 0; w < 8 && base + w < wq.size(); w++) begin
      check($sformatf("%s_addr%0d", nm, w), {13'd0, wq[base+w].a}, 32'(a0 + (w / 2) * 320 + (w % 2)));
      check($sformatf("%s_data%0d", nm, w), {16'd0, wq[base+w].d}, 32'(16'hA000 | 16'(rom0 + w)));
    end
  endtask

  task automatic wait_we(input string nm);
    int k;
    k = 0;
    while (!bus.fb_we && k < 60) begin
      step();
      k++;
    end
    check({nm, "_we_seen"}, {31'd0, bus.fb_we}, 32'd1);
  endtask

  initial begin
    rows[0] = '{0,  4,  5, 2'b11,  6406,  0, 2'b00};
    rows[1] = '{1,  9, 10, 2'b10, 12820, 48, 2'b00};
    rows[2] = '{1,  8, 10, 2'b10, 12818, 32, 2'b00};
    rows[3] = '{0,  9, 10, 2'b11,  6408,  0, 2'b01};
    rows[4] = '{1, 10, 10, 2'b10, 12816, 32, CS};
    rows[5] = '{1, 10, 11, 2'b01, 12820, 48, CS};
    rows[6] = '{1, 10, 12, 2'b01, 14100, 40, CS};

    rst = 1'b1;
    bus.frame_clk = 1'b0;
    bus.active    = 1'b0;
    bus.clear     = 1'b0;
    bus.fb_ready  = 1'b1;
    px[0] = 3;  py[0] = 5;  pd[0] = 2'b11;
    px[1] = 10; py[1] = 10; pd[1] = 2'b00;
    drive_pos();
    repeat (3) step();
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_we", {31'd0, bus.fb_we}, 0);
    check("rst_coll", {30'd0, bus.collision}, 0);
    check("rst_ovr", {31'd0, bus.overrun}, 0);
    check("rst_rom", {26'd0, bus.rom_addr}, 0);
    check("rst_fbaddr", {13'd0, bus.fb_addr}, 0);
    rst = 1'b0;
    repeat (2) step();

    bus.active = 1'b1;
    bus.clear  = 1'b1;
    step();
    bus.clear  = 1'b0;
    run_idle("clear", 5000, 1'b0, n);
    check("clear_len", {31'd0, (n >= 4096 && n <= 4100)}, 1);
    check("clear_coll", {30'd0, bus.collision}, 0);

    for (int i = 0; i < 7; i++) begin
      px[rows[i].p] = rows[i].nx;
      py[rows[i].p] = rows[i].ny;
      pd[rows[i].p] = rows[i].nd;
      drive_pos();
      wq.delete();
      pulse_tick(1'b0);
      run_idle($sformatf("row%0d", i), 200, 1'b0, n);
      check($sformatf("row%0d_nwr", i), wq.size(), 8);
      check_tile($sformatf("row%0d", i), 0, rows[i].a0, rows[i].rom0);
      check($sformatf("row%0d_coll", i), {30'd0, bus.collision}, {30'd0, rows[i].coll});
    end

    // Both players on one tick, fb_ready toggling.
    px[0] = 9;  py[0] = 11;
    px[1] = 10; py[1] = 13;
    drive_pos();
    wq.delete();
    pulse_tick(1'b0);
    run_idle("both", 500, 1'b1, n);
    check("both_nwr", wq.size(), 16);
    check_tile("both_p0", 0, 12818, 0);
    check_tile("both_p1", 8, 15380, 40);
    check("both_ovr", {31'd0, bus.overrun}, 0);

    // Second tick arriving while the first tile is being written.
    py[0] = 12;
    drive_pos();
    wq.delete();
    pulse_tick(1'b0);
    n = 0;
    while (wq.size() == 0 && n < 50) begin
      step();
      n++;
    end
    check("ovr_first_write", {31'd0, wq.size() > 0}, 1);
    py[0] = 13;
    drive_pos();
    pulse_tick(1'b0);
    run_idle("ovr", 500, 1'b0, n);
    check("ovr_flag", {31'd0, bus.overrun}, 1);
    check("ovr_nwr", wq.size(), 16);
    check_tile("ovr_t0", 0, 14098, 0);
    check_tile("ovr_t1", 8, 15378, 0);

    // Dropping active mid-write aborts and discards the other pending job.
    py[0] = 14;
    py[1] = 14;
    drive_pos();
    bus.fb_ready = 1'b0;
    wq.delete();
    pulse_tick(1'b0);
    wait_we("act");
    bus.active = 1'b0;
    #1;
    check("act_we_drop", {31'd0, bus.fb_we}, 0);
    step();
    check("act_busy", {31'd0, bus.busy}, 0);
    bus.fb_ready = 1'b1;
    px[1] = 30; py[1] = 20; pd[1] = 2'b10;
    drive_pos();
    repeat (3) step();
    bus.active = 1'b1;
    step();
    pulse_tick(1'b0);
    repeat (25) step();
    check("act_no_wr", wq.size(), 0);
    check("act_idle", {31'd0, bus.busy}, 0);

    // Clear together with a tick: wipe wins, tick dropped.
    px[0] = 20; py[0] = 20;
    drive_pos();
    wq.delete();
    pulse_tick(1'b1);
    run_idle("clrtick", 5000, 1'b0, n);
    check("clrtick_nwr", wq.size(), 0);
    check("clrtick_coll", {30'd0, bus.collision}, 0);
    check("clrtick_ovr", {31'd0, bus.overrun}, 0);
    px[0] = 10; py[0] = 10;
    drive_pos();
    pulse_tick(1'b0);
    run_idle("postclr", 200, 1'b0, n);
    check("postclr_nwr", wq.size(), 8);
    check_tile("postclr", 0, 17938, 0);
    check("postclr_coll", {30'd0, bus.collision}, 0);

    // Asynchronous reset in the middle of a tile.
    px[0] = 11;
    drive_pos();
    bus.fb_ready = 1'b0;
    pulse_tick(1'b0);
    wait_we("rstwr");
    #2;
    rst = 1'b1;
    #1;
    check("rstwr_we", {31'd0, bus.fb_we}, 0);
    check("rstwr_busy", {31'd0, bus.busy}, 0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trail_writer_mp.md
Name: trail_writer_mp

Overview:
- Parametrised multi-player trail engine for the light-cycle game.
- On each frame tick, detects every player whose cell position changed and records the vacated cell in an internal occupancy grid.
- Streams that cell's trail tile (horizontal, vertical or corner) from an external tile ROM into the frame buffer through a ready/valid write port.
- Flags a collision when a player enters an occupied cell.

Parameters:
- NUM_PLAYERS, 2: number of cycles tracked.
- GRID_W, 6: bits per X/Y cell coordinate; grid holds 2^(2*GRID_W) cells.
- TILE_H, 4: frame-buffer rows per tile.
- TILE_WPR, 2: DATA_W-bit words per tile row.
- ROW_PITCH, 320: words per frame-buffer row.
- FB_BASE, 0: frame-buffer word address of cell (0,0).
- ADDR_W, 19: frame-buffer address width.
- DATA_W, 16: pixel word width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous active-high reset.
- frame_clk  in  1  one-cycle frame tick.
- active  in  1  game running; low holds the block in IDLE.
- clear  in  1  one-cycle pulse; starts an occupancy-grid wipe.
- pos_x  in  NUM_PLAYERS*GRID_W  per-player X cell, player p at [p*GRID_W +: GRID_W].
- pos_y  in  NUM_PLAYERS*GRID_W  per-player Y cell.
- dir  in  NUM_PLAYERS*2  direction: 00 up, 01 down, 10 left, 11 right.
- rom_addr  out  clog2(NUM_PLAYERS)+2+clog2(TILE_H*TILE_WPR)  {player, kind, word}.
- rom_data  in  DATA_W  tile word, valid 1 cycle after rom_addr.
- fb_addr  out  ADDR_W  frame-buffer word address.
- fb_data  out  DATA_W  word to write.
- fb_we  out  1  write valid.
- fb_ready  in  1  frame buffer accepts the word when fb_we&&fb_ready.
- collision  out  NUM_PLAYERS  sticky per-player collision flags.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; a frame_clk arrived while busy.

Behaviour:
- Reset is asynchronous. All outputs go to 0. State goes to IDLE. Old-position/direction registers and pending flags go to 0. Grid contents are undefined until a clear completes.
- Grid cell code: 0 = empty, p+1 = trail of player p.
- Tile kind: 0 horizontal (dir 1x), 1 vertical (dir 0x), 2 corner (dir differs from the old direction).
- Tick sampling: on frame_clk with active=1, for each p with (x,y)≠(old_x,old_y), set pending[p]. Latch the old position and old direction into the job, then update old := current. Change is detected on X or Y.
- States:
  - IDLE: go to CLEAR if clear; else go to SEL if any pending.
  - SEL: pick the lowest-index pending p and clear pending[p]. If none remain, go to IDLE.
  - CHK: read the grid at p's new cell (1-cycle read). If nonzero, set collision[p]. Go to MARK.
  - MARK: write p+1 at p's old cell. Go to FETCH.
  - FETCH: drive rom_addr for word 0. Go to WR.
  - WR: present fb_addr = FB_BASE + (old_y*TILE_H+r)*ROW_PITCH + old_x*TILE_WPR + c, with fb_data = rom_data and fb_we=1.
    - Hold all three until fb_ready.
    - On accept, advance c, then r (row-major). Re-issue rom_addr, which costs one bubble cycle with fb_we=0.
    - After the final word, go to SEL.
  - CLEAR: write 0 to one cell per cycle, address 0 to 2^(2*GRID_W)-1, then go to IDLE. Also clears collision, pending and overrun.
- Arithmetic: fb_addr is computed in ADDR_W bits; overflow wraps silently.
- Simultaneous events:
  - frame_clk while busy: sample normally, set overrun, and merge into pending. A player already pending has its job overwritten with the newer old/new pair.
  - clear together with frame_clk: clear wins and the tick is dropped.
  - Head-on collision (two players entering the same cell on one tick): only players checked after an earlier MARK of that cell see it. Both flags are set only if the cell was already occupied.
- active low: the state machine returns to IDLE within 1 cycle, fb_we drops immediately, and pending is cleared. Old registers keep tracking pos/dir every cycle, so resuming does not draw a spurious trail.
- Reset mid-WR: fb_we drops asynchronously and the partial tile stays in the frame buffer.

Optional Feature:
- TRAIL_SELF_HIT_EN
- Defined: entering a cell that holds the player's own code sets its collision flag.
- Undefined: only codes ≠ p+1 (and ≠0) count, so self-trail is ignored.

Test Plan:
- Reset, pulse clear, then wait 4096 cycles (GRID_W=6). Expected: busy=0, all grid reads return 0, collision=00.
- Player0 (3,5)→(4,5), dir 11 both ticks, fb_ready=1. Expected: 8 writes, first fb_addr=20*320+6=6406 with rom_addr {0,0,0}, then 6407, 6726, ...; busy drops after the 8th.
- Player1 turns (dir 00→10) while moving (10,10)→(9,10). Expected: rom kind=2 (corner) and grid cell (10,10)=2.
- Player1 trail at (9,10), player0 moves into (9,10). Expected: collision[0]=1, collision[1]=0.
- Both players move on the same tick with fb_ready toggling 1/0. Expected: player0's 8 writes all complete before player1's first; no write lost or duplicated.
- Second frame_clk during WR. Expected: overrun=1, and the newer position is drawn after the current tile.
